instr_fetch_seq: RTL and testbench
==================================

// Module: instr_fetch_seq
// PURPOSE
//  Fetch sequencer sitting directly downstream of the PC register. On request it drives the PC value to memory as a
//  read address and waits for the memory handshake. It latches the returned word into an instruction register and
//  issues a single one-cycle increment pulse back to the PC register's incPC input. A memory timeout raises a sticky fault.
// PARAMETERS
//  DATA_W    32  width of instruction word / mem_rdata / ir
//  ADDR_W    32  width of pc input and mem_addr output
//  WAIT_MAX  15  max READ cycles without mem_ack before fault; 0 = timeout disabled
// PORTS
//  clk          in   1       single clock, all state updates on posedge
//  clr          in   1       reset, synchronous, active-high; dominates every other input
//  start        in   1       fetch request from control unit, sampled in IDLE (and HOLD, see below)
//  pc           in   ADDR_W  current PC (Q of PC register), sampled only in ADDR
//  mem_addr     out  ADDR_W  registered read address
//  mem_rd       out  1       registered read request, held until mem_ack
//  mem_ack      in   1       memory read-complete; mem_rdata valid same cycle
//  mem_rdata    in   DATA_W  read data
//  inc_pc       out  1       registered one-cycle pulse -> PC register incPC (PC += 4)
//  ir           out  DATA_W  instruction register
//  ir_valid     out  1       ir holds an unconsumed instruction
//  ir_taken     in   1       consumer accepts ir (meaningful only while ir_valid)
//  busy         out  1       state != IDLE (combinational from state reg)
//  fetch_fault  out  1       sticky timeout flag, cleared only by clr
// BEHAVIOUR
//  Reset (clr at edge): state=IDLE; mem_addr, mem_rd, inc_pc, ir, ir_valid, fetch_fault, wait count all 0.
//  States: IDLE, ADDR, READ, HOLD, FAULT.
//   IDLE : start=1 -> ADDR; otherwise stay. inc_pc forced 0.
//   ADDR : mem_addr<=pc, mem_rd<=1, count<=0 -> READ (exactly one cycle).
//   READ : mem_ack=1 -> ir<=mem_rdata, mem_rd<=0, ir_valid<=1, inc_pc<=1 -> HOLD.
//          mem_ack=0 & WAIT_MAX!=0 & count==WAIT_MAX-1 -> mem_rd<=0, fetch_fault<=1 -> FAULT.
//          else count<=count+1, stay. Ack on the limit edge wins over timeout.
//   HOLD : inc_pc<=0 (pulse is exactly one cycle). ir_taken=1 -> ir_valid<=0; if start also 1 -> ADDR
//          (back-to-back fetch), else IDLE. ir_taken=0 -> stay, ir stable.
//   FAULT: all outputs held, mem_rd=0, inc_pc=0; exit only via clr.
//  Latency: start sampled at edge N -> mem_addr/mem_rd valid after N+1 -> earliest ack at edge N+2 ->
//   ir/ir_valid/inc_pc high after N+2; inc_pc low after N+3. mem_rd high >= 1 cycle.
//  One inc_pc pulse per successful fetch; none on fault or abort. pc must be stable in ADDR only.
//  Ignored: start in ADDR/READ/FAULT (not queued); mem_ack outside READ; ir_taken while ir_valid=0; pc outside ADDR.
//  clr mid-READ: abort, mem_rd=0 next cycle, no inc_pc, ir=0; a late ack after reset is ignored (state IDLE).
//  Count width $clog2(WAIT_MAX+1), never wraps (cleared in ADDR, bounded by fault).
// STRUCTURE
//  fetch_pkg: state encodings (S_IDLE..S_FAULT, 3 bits), PC_STEP=4 note, default DATA_W/ADDR_W.
//  Sub-module wait_timer (clr, clk, restart, run, limit -> expired): saturating counter for READ timeout.
//  Remainder is one FSM always-block plus output registers in instr_fetch_seq.
// TESTING
//  1 clr high 2 cycles with random inputs -> every output 0, busy=0.
//  2 pc=0x100, start 1 cycle, ack first READ cycle, rdata=0xDEADBEEF -> mem_addr=0x100, mem_rd 1 cycle,
//    ir=0xDEADBEEF & ir_valid after edge N+2, inc_pc exactly 1 cycle; PC model reads 0x104.
//  3 ack delayed 5 cycles, WAIT_MAX=15 -> mem_rd high 6 cycles, single inc_pc, no fault.
//  4 WAIT_MAX=4, no ack -> fetch_fault after 4th READ cycle, mem_rd low, no inc_pc, state held until clr;
//    variant: ack on 4th cycle -> normal completion, no fault.
//  5 HOLD with ir_taken=1 & start=1, pc=0x104 -> direct ADDR, mem_addr=0x104, second ir after 2 more edges.
//  6 clr during READ, then ack next cycle -> outputs 0, no inc_pc, ir stays 0, busy=0.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
// The sequencer emits one inc_pc pulse per completed fetch and the PC register adds PC_STEP on it.
package fetch_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 32;
    localparam int PC_STEP    = 4;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ADDR  = 3'd1,
        S_READ  = 3'd2,
        S_HOLD  = 3'd3,
        S_FAULT = 3'd4
    } state_t;

    // A limit of 0 disables the timeout, but the counter still needs one bit.
    function automatic int cnt_width(input int wait_max);
        return (wait_max < 1) ? 1 : $clog2(wait_max + 1);
    endfunction

endpackage

// File: rtl/instr_fetch_seq_wait_timer.sv
// Saturating wait counter for the READ phase; expired flags the last allowed cycle without an ack.
// limit == 0 means the timeout is disabled and expired never asserts.
module wait_timer #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             restart,
    input  logic             run,
    input  logic [CNT_W-1:0] limit,
    output logic             expired
);

    logic [CNT_W-1:0] count;
    logic             at_limit;

    assign at_limit = (limit != '0) && (count == limit - 1'b1);
    assign expired  = run && at_limit;

    always_ff @(posedge clk) begin
        if (clr || restart) begin
            count <= '0;
        end else if (run && !at_limit) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/instr_fetch_seq.sv
// Fetch sequencer: reads the word at pc, latches it into ir and pulses inc_pc once per successful fetch.
// A memory that never acks within WAIT_MAX READ cycles parks the sequencer in FAULT until clr.
module instr_fetch_seq
    import fetch_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int WAIT_MAX = 15
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              start,
    input  logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              inc_pc,
    output logic [DATA_W-1:0] ir,
    output logic              ir_valid,
    input  logic              ir_taken,
    output logic              busy,
    output logic              fetch_fault,
    output state_t            state
);

    localparam int CNT_W = cnt_width(WAIT_MAX);

    logic timer_restart;
    logic timer_run;
    logic timer_expired;

    // Handshakes: mem_rd stays high until the cycle mem_ack is seen in READ (data captured that edge);
    // ir_valid stays high until the cycle ir_taken is seen in HOLD. Neither side is queued elsewhere.
    assign timer_restart = (state == S_ADDR);
    assign timer_run     = (state == S_READ) && !mem_ack;
    assign busy          = (state != S_IDLE);

    wait_timer #(
        .CNT_W(CNT_W)
    ) u_wait_timer (
        .clk     (clk),
        .clr     (clr),
        .restart (timer_restart),
        .run     (timer_run),
        .limit   (CNT_W'(WAIT_MAX)),
        .expired (timer_expired)
    );

    always_ff @(posedge clk) begin
        if (clr) begin
            state       <= S_IDLE;
            mem_addr    <= '0;
            mem_rd      <= 1'b0;
            inc_pc      <= 1'b0;
            ir          <= '0;
            ir_valid    <= 1'b0;
            fetch_fault <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    inc_pc <= 1'b0;
                    if (start) begin
                        state <= S_ADDR;
                    end
                end
                S_ADDR: begin
                    mem_addr <= pc;
                    mem_rd   <= 1'b1;
                    state    <= S_READ;
                end
                S_READ: begin
                    // An ack on the limit cycle wins: timer_expired is gated off by mem_ack.
                    if (mem_ack) begin
                        ir       <= mem_rdata;
                        mem_rd   <= 1'b0;
                        ir_valid <= 1'b1;
                        inc_pc   <= 1'b1;
                        state    <= S_HOLD;
                    end else if (timer_expired) begin
                        mem_rd      <= 1'b0;
                        fetch_fault <= 1'b1;
                        state       <= S_FAULT;
                    end
                end
                S_HOLD: begin
                    inc_pc <= 1'b0;
                    if (ir_taken) begin
                        ir_valid <= 1'b0;
                        state    <= start ? S_ADDR : S_IDLE;
                    end
                end
                S_FAULT: begin
                    mem_rd <= 1'b0;
                    inc_pc <= 1'b0;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch_seq.sv
// Two sequencers (WAIT_MAX 15 and 4) share one stimulus stream; each has its own expected-event queue.
// Expected events come from fetch-level rules: ack delay vs. limit gives completion cycle or fault cycle.
module tb_instr_fetch_seq;
    import fetch_pkg::*;

    localparam int W   = 32;
    localparam int WM0 = 15;
    localparam int WM1 = 4;

    typedef struct packed {
        bit           fault;
        logic [W-1:0] addr;
        logic [W-1:0] data;
        int           cyc;
        int           rd;
    } exp_t;

    logic         clk = 1'b0;
    logic         clr;
    logic         start;
    logic         mem_ack;
    logic         ir_taken;
    logic [W-1:0] pc;
    logic [W-1:0] mem_rdata;

    logic [W-1:0] mem_addr_s [2];
    logic [W-1:0] ir_s       [2];
    logic         mem_rd_s   [2];
    logic         inc_pc_s   [2];
    logic         ir_valid_s [2];
    logic         busy_s     [2];
    logic         fault_s    [2];
    logic [2:0]   state_s    [2];

    exp_t exp_q0[$];
    exp_t exp_q1[$];
    bit   faulted [2] = '{1'b0, 1'b0};
    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;
    int   ok0    = 0;

    int           rd_cnt     [2] = '{0, 0};
    logic         prev_fault [2] = '{1'b0, 1'b0};
    logic         prev_valid [2] = '{1'b0, 1'b0};
    logic [W-1:0] prev_ir    [2];
    logic [W-1:0] pc_model = 32'h100;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (inc_pc_s[0] === 1'b1) pc_model <= pc_model + PC_STEP;
    end

    instr_fetch_seq #(.DATA_W(W), .ADDR_W(W), .WAIT_MAX(WM0)) dut0 (
        .clk(clk), .clr(clr), .start(start), .pc(pc),
        .mem_addr(mem_addr_s[0]), .mem_rd(mem_rd_s[0]), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .inc_pc(inc_pc_s[0]), .ir(ir_s[0]), .ir_valid(ir_valid_s[0]), .ir_taken(ir_taken),
        .busy(busy_s[0]), .fetch_fault(fault_s[0]), .state(state_s[0])
    );

    instr_fetch_seq #(.DATA_W(W), .ADDR_W(W), .WAIT_MAX(WM1)) dut1 (
        .clk(clk), .clr(clr), .start(start), .pc(pc),
        .mem_addr(mem_addr_s[1]), .mem_rd(mem_rd_s[1]), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .inc_pc(inc_pc_s[1]), .ir(ir_s[1]), .ir_valid(ir_valid_s[1]), .ir_taken(ir_taken),
        .busy(busy_s[1]), .fetch_fault(fault_s[1]), .state(state_s[1])
    );

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    // A fetch started at edge n with `delay` ack-less READ cycles completes at n+2+delay,
    // unless delay reaches the limit: then the fault lands at n+1+limit.
    task automatic push_exp(input logic [W-1:0] addr, input logic [W-1:0] data, input int n, input int delay);
        for (int i = 0; i < 2; i++) begin
            exp_t r;
            int   wm;
            wm = (i == 0) ? WM0 : WM1;
            if (faulted[i]) continue;
            r.addr = addr;
            r.data = data;
            if (wm == 0 || delay < wm) begin
                r.fault = 1'b0;
                r.cyc   = n + 2 + delay;
                r.rd    = delay + 1;
                if (i == 0) ok0++;
            end else begin
                r.fault    = 1'b1;
                r.cyc      = n + 1 + wm;
                r.rd       = wm;
                faulted[i] = 1'b1;
            end
            if (i == 0) exp_q0.push_back(r);
            else        exp_q1.push_back(r);
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    task automatic monitor_inst(input int i);
        exp_t r;
        bit   empty;
        if (mem_rd_s[i] === 1'b1) rd_cnt[i]++;
        if (inc_pc_s[i] === 1'b1 || (fault_s[i] === 1'b1 && prev_fault[i] !== 1'b1)) begin
            empty = (i == 0) ? (exp_q0.size() == 0) : (exp_q1.size() == 0);
            if (empty) begin
                checks++;
                errors++;
                $display("FAIL unexpected_event inst%0d: inc_pc=%b fault=%b at cycle %0d, expected none",
                         i, inc_pc_s[i], fault_s[i], cyc);
            end else begin
                r = (i == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
                chk($sformatf("fault_flag%0d", i), W'(fault_s[i]), W'(r.fault));
                chk($sformatf("event_cycle%0d", i), cyc, r.cyc);
                chk($sformatf("mem_addr%0d", i), mem_addr_s[i], r.addr);
                chk($sformatf("mem_rd_cycles%0d", i), rd_cnt[i], r.rd);
                if (!r.fault) begin
                    chk($sformatf("ir%0d", i), ir_s[i], r.data);
                    chk($sformatf("ir_valid%0d", i), W'(ir_valid_s[i]), 1);
                    chk($sformatf("busy_hold%0d", i), W'(busy_s[i]), 1);
                end else begin
                    chk($sformatf("mem_rd_fault%0d", i), W'(mem_rd_s[i]), 0);
                    chk($sformatf("inc_pc_fault%0d", i), W'(inc_pc_s[i]), 0);
                end
            end
            rd_cnt[i] = 0;
        end
        if (busy_s[i] !== 1'b1) rd_cnt[i] = 0;
        if (prev_valid[i] === 1'b1 && ir_valid_s[i] === 1'b1 && inc_pc_s[i] !== 1'b1)
            chk($sformatf("ir_stable%0d", i), ir_s[i], prev_ir[i]);
        prev_fault[i] = fault_s[i];
        prev_valid[i] = ir_valid_s[i];
        prev_ir[i]    = ir_s[i];
    endtask

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) monitor_inst(i);
    end

    // ---------------- driver tasks ----------------
    task automatic reset_check();
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("rst_mem_addr%0d", i), mem_addr_s[i], 0);
            chk($sformatf("rst_mem_rd%0d", i), W'(mem_rd_s[i]), 0);
            chk($sformatf("rst_inc_pc%0d", i), W'(inc_pc_s[i]), 0);
            chk($sformatf("rst_ir%0d", i), ir_s[i], 0);
            chk($sformatf("rst_ir_valid%0d", i), W'(ir_valid_s[i]), 0);
            chk($sformatf("rst_fault%0d", i), W'(fault_s[i]), 0);
            chk($sformatf("rst_busy%0d", i), W'(busy_s[i]), 0);
            chk($sformatf("rst_state%0d", i), W'(state_s[i]), W'(S_IDLE));
        end
    endtask

    task automatic do_clr(input int cycles);
        clr = 1'b1;
        for (int c = 0; c < cycles; c++) begin
            start     = 1'($urandom_range(0, 1));
            mem_ack   = 1'($urandom_range(0, 1));
            ir_taken  = 1'($urandom_range(0, 1));
            pc        = $urandom;
            mem_rdata = $urandom;
            @(negedge clk);
        end
        clr = 1'b0; start = 1'b0; mem_ack = 1'b0; ir_taken = 1'b0;
        chk("pending_q0", exp_q0.size(), 0);
        chk("pending_q1", exp_q1.size(), 0);
        exp_q0.delete();
        exp_q1.delete();
        faulted = '{1'b0, 1'b0};
        reset_check();
    endtask

    task automatic idle(input int cycles);
        for (int c = 0; c < cycles; c++) begin
            start = 1'b0; ir_taken = 1'b0; mem_ack = 1'($urandom_range(0, 1)); pc = $urandom;
            @(negedge clk);
        end
        mem_ack = 1'b0;
    endtask

    // Called at a negedge with the DUTs in IDLE or HOLD; returns at the negedge after the ack edge.
    task automatic fetch(input logic [W-1:0] addr, input logic [W-1:0] data, input int delay, input int gap);
        int n;
        for (int g = 0; g < gap; g++) begin
            start = 1'b0; ir_taken = 1'($urandom_range(0, 1)); mem_ack = 1'($urandom_range(0, 1));
            mem_rdata = $urandom; pc = $urandom;
            @(negedge clk);
        end
        start = 1'b1; ir_taken = 1'b1; mem_ack = 1'($urandom_range(0, 1));
        mem_rdata = $urandom; pc = $urandom;
        n = cyc + 1;
        push_exp(addr, data, n, delay);
        @(negedge clk);
        start = 1'($urandom_range(0, 1)); ir_taken = 1'($urandom_range(0, 1));
        mem_ack = 1'($urandom_range(0, 1)); pc = addr;
        @(negedge clk);
        pc = $urandom;
        for (int d = 0; d < delay; d++) begin
            mem_ack = 1'b0; mem_rdata = $urandom;
            start = 1'($urandom_range(0, 1)); ir_taken = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        mem_ack = 1'b1; mem_rdata = data;
        @(negedge clk);
        start = 1'b0; ir_taken = 1'b0; mem_ack = 1'b0;
    endtask

    task automatic abort_read();
        start = 1'b1; ir_taken = 1'b0; mem_ack = 1'b0; pc = 32'h500;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0; mem_ack = 1'b1; mem_rdata = 32'hBAD0BAD0;
        @(negedge clk);
        mem_ack = 1'b0;
        reset_check();
    endtask

    // ---------------- test sequence ----------------
    initial begin
        clr = 1'b1; start = 1'b0; mem_ack = 1'b0; ir_taken = 1'b0; pc = '0; mem_rdata = '0;
        @(negedge clk);
        do_clr(2);

        fetch(32'h100, 32'hDEADBEEF, 0, 1);
        idle(1);
        chk("pc_model_first", pc_model, 32'h104);

        fetch(32'h200, $urandom, 5, 1);
        idle(3);
        chk("sticky_fault1", W'(fault_s[1]), 1);
        chk("sticky_mem_rd1", W'(mem_rd_s[1]), 0);
        chk("sticky_busy1", W'(busy_s[1]), 1);
        chk("sticky_state1", W'(state_s[1]), W'(S_FAULT));
        do_clr(1);

        fetch(32'h300, $urandom, 3, 0);
        fetch(32'h400, $urandom, 4, 2);
        do_clr(1);

        fetch(32'h100, $urandom, 0, 1);
        fetch(32'h104, $urandom, 0, 0);
        idle(2);
        do_clr(1);

        abort_read();
        idle(2);

        for (int t = 0; t < 40; t++) begin
            int delay;
            delay = ($urandom_range(0, 9) == 0) ? $urandom_range(4, 17) : $urandom_range(0, 5);
            fetch($urandom, $urandom, delay, $urandom_range(0, 3));
            if (faulted[0] || faulted[1]) do_clr($urandom_range(1, 2));
        end
        idle(2);

        chk("pc_model_final", pc_model, 32'h100 + W'(PC_STEP * ok0));
        chk("final_q0_empty", exp_q0.size(), 0);
        chk("final_q1_empty", exp_q1.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
